// File: rtl/inv_shiftrow.sv
// inv_shiftrow: byte-serial AES InvShiftRows with two ping-pong 16-byte banks.
// Define INV_SHIFTROW_FWD_EN to add port fwd, which selects forward ShiftRows per block.
module inv_shiftrow #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef INV_SHIFTROW_FWD_EN
   input  logic          fwd,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);
   logic [15:0][DW-1:0] bank0_q, bank0_d, bank1_q, bank1_d;
   logic [1:0] full_q, full_d;
   logic       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
   logic [3:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [3:0] src;
   logic [1:0] src_col;
   logic       wr_acc, rd_acc, wr_last, rd_last, rd_fwd;
`ifdef INV_SHIFTROW_FWD_EN
   logic [1:0] mode_q, mode_d;
   assign rd_fwd = mode_q[rd_sel_q];
`else
   assign rd_fwd = 1'b0;
`endif

   always_comb begin
      in_ready  = ~full_q[wr_sel_q];
      out_valid = full_q[rd_sel_q];
      wr_acc    = in_valid & in_ready;
      rd_acc    = out_valid & out_ready;
      wr_last   = wr_acc && (wr_cnt_q == 4'd15);
      rd_last   = rd_acc && (rd_cnt_q == 4'd15);
      bank0_d   = bank0_q;
      bank1_d   = bank1_q;
      if (wr_acc && !wr_sel_q) bank0_d[wr_cnt_q] = in_data;
      if (wr_acc && wr_sel_q) bank1_d[wr_cnt_q] = in_data;
      // Write and read completions always target different banks
      full_d = full_q;
      if (wr_last) full_d[wr_sel_q] = 1'b1;
      if (rd_last) full_d[rd_sel_q] = 1'b0;
      wr_cnt_d = wr_cnt_q + {3'b000, wr_acc};
      rd_cnt_d = rd_cnt_q + {3'b000, rd_acc};
      wr_sel_d = wr_sel_q ^ wr_last;
      rd_sel_d = rd_sel_q ^ rd_last;
`ifdef INV_SHIFTROW_FWD_EN
      mode_d = mode_q;
      if (wr_last) mode_d[wr_sel_q] = fwd;
`endif
      // Output byte r+4c reads column c-r (inverse) or c+r (forward) of row r
      src_col  = rd_fwd ? rd_cnt_q[3:2] + rd_cnt_q[1:0] : rd_cnt_q[3:2] - rd_cnt_q[1:0];
      src      = {src_col, rd_cnt_q[1:0]};
      out_data = out_valid ? (rd_sel_q ? bank1_q[src] : bank0_q[src]) : '0;
   end

   always_ff @(posedge clk) begin
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q   <= '0;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
`ifdef INV_SHIFTROW_FWD_EN
         mode_q   <= '0;
`endif
      end else begin
         full_q   <= full_d;
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
`ifdef INV_SHIFTROW_FWD_EN
         mode_q   <= mode_d;
`endif
      end
   end
endmodule
